// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - start/busy/done request and result bundle for alu_seq
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       ALUctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             c_out;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output start, ALUctl, a, b,
        input  result, result_hi, c_out, zero, busy, done
    );

    modport slave (
        input  start, ALUctl, a, b,
        output result, result_hi, c_out, zero, busy, done
    );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered WIDTH-bit ALU, iterative MUL, optional iterative DIVU
// Divider datapath is compiled in only when ALU_DIV_EN is defined.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_XOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;
`ifdef ALU_DIV_EN
    localparam logic [3:0] OP_DIVU = 4'b1001;
`endif

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] result_hi_r;
    logic             c_out_r;
    logic             zero_r;
`ifdef ALU_DIV_EN
    logic             is_div;
`endif

    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH-1:0] sc_result;
    logic             sc_cout;
    logic             is_multi;

    always_comb begin
        add_w     = {1'b0, bus.a} + {1'b0, bus.b};
        sub_w     = {1'b0, bus.a} - {1'b0, bus.b};
        sc_result = '0;
        sc_cout   = 1'b0;
        is_multi  = (bus.ALUctl == OP_MUL);
`ifdef ALU_DIV_EN
        if (bus.ALUctl == OP_DIVU)
            is_multi = 1'b1;
`endif
        case (bus.ALUctl)
            OP_AND: sc_result = bus.a & bus.b;
            OP_OR:  sc_result = bus.a | bus.b;
            OP_XOR: sc_result = bus.a ^ bus.b;
            OP_ADD: begin
                sc_result = add_w[WIDTH-1:0];
                sc_cout   = add_w[WIDTH];
            end
            OP_SUB: begin
                sc_result = sub_w[WIDTH-1:0];
                sc_cout   = ~sub_w[WIDTH];
            end
            // Sign of the sign-extended (WIDTH+1)-bit difference: the operand
            // sign bits folded with the borrow out of the unsigned subtract.
            OP_SLT: sc_result = {{(WIDTH-1){1'b0}},
                                 bus.a[WIDTH-1] ^ bus.b[WIDTH-1] ^ sub_w[WIDTH]};
            default: ;
        endcase
    end

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] step_q;
`ifdef ALU_DIV_EN
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
`endif

    // {acc, q} is the double-width product / remainder:quotient register.
    always_comb begin
        mul_sum  = {1'b0, acc} + (q[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        step_acc = mul_sum[WIDTH:1];
        step_q   = {mul_sum[0], q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        rem_sh   = {acc, q[WIDTH-1]};
        div_ge   = (rem_sh >= {1'b0, opb});
        div_diff = rem_sh[WIDTH-1:0] - opb;
        if (is_div) begin
            step_acc = div_ge ? div_diff : rem_sh[WIDTH-1:0];
            step_q   = {q[WIDTH-2:0], div_ge};
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            opb         <= '0;
            acc         <= '0;
            q           <= '0;
            result_r    <= '0;
            result_hi_r <= '0;
            c_out_r     <= 1'b0;
            zero_r      <= 1'b1;
`ifdef ALU_DIV_EN
            is_div      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (is_multi) begin
                            opb   <= bus.b;
                            acc   <= '0;
                            q     <= bus.a;
                            cnt   <= CNT_INIT;
`ifdef ALU_DIV_EN
                            is_div <= (bus.ALUctl == OP_DIVU);
`endif
                            state <= S_RUN;
                        end else begin
                            result_r    <= sc_result;
                            result_hi_r <= '0;
                            c_out_r     <= sc_cout;
                            zero_r      <= (sc_result == '0);
                            state       <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    acc <= step_acc;
                    q   <= step_q;
                    cnt <= cnt - CNT_LAST;
                    if (cnt == CNT_LAST) begin
                        result_r    <= step_q;
                        result_hi_r <= step_acc;
                        c_out_r     <= 1'b0;
                        zero_r      <= (step_q == '0);
                        state       <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.result    = result_r;
    assign bus.result_hi = result_hi_r;
    assign bus.c_out     = c_out_r;
    assign bus.zero      = zero_r;
    assign bus.busy      = (state == S_RUN);
    assign bus.done      = (state == S_DONE);
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq (WIDTH=8 directed, WIDTH=32 random)
module tb_alu_seq;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    alu_seq_if #(.WIDTH(8))  i8 ();
    alu_seq_if #(.WIDTH(32)) i32 ();

    alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(i8));
    alu_seq #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(i32));

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       c;
        logic       z;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one op on the 8-bit unit, waits for done, captures outputs, returns to IDLE.
    task automatic issue8(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                          output int lat, output logic [7:0] r, output logic [7:0] hi,
                          output logic c, output logic z);
        i8.start = 1'b1; i8.ALUctl = op; i8.a = x; i8.b = y;
        tick();
        i8.start = 1'b0; i8.ALUctl = 4'($urandom); i8.a = 8'($urandom); i8.b = 8'($urandom);
        lat = 1;
        while (i8.done !== 1'b1 && lat < 64) begin
            tick();
            lat++;
        end
        if (i8.done !== 1'b1) lat = -1;
        r = i8.result; hi = i8.result_hi; c = i8.c_out; z = i8.zero;
        tick();
    endtask

    function automatic void model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [31:0] hi,
                                  output logic c, output logic z, output int lat);
        logic [63:0] p;
        r = '0; hi = '0; c = 1'b0; lat = 1;
        case (op)
            OP_AND: r = x & y;
            OP_OR:  r = x | y;
            OP_XOR: r = x ^ y;
            OP_ADD: begin p = {32'd0, x} + {32'd0, y}; r = p[31:0]; c = p[32]; end
            OP_SUB: begin r = x - y; c = (x >= y); end
            OP_SLT: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            OP_MUL: begin p = {32'd0, x} * {32'd0, y}; r = p[31:0]; hi = p[63:32]; lat = 33; end
`ifdef ALU_DIV_EN
            OP_DIVU: begin
                lat = 33;
                if (y == 0) begin r = '1; hi = x; end
                else begin r = x / y; hi = x % y; end
            end
`endif
            default: ;
        endcase
        z = (r == 0);
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        int lat;
        logic [7:0] r, hi;
        logic c, z;
        reset = 1'b1;
        i8.start = 1'b0; i8.ALUctl = 4'd0; i8.a = 8'd0; i8.b = 8'd0;
        i32.start = 1'b0; i32.ALUctl = 4'd0; i32.a = 32'd0; i32.b = 32'd0;
        tick(); tick();
        tests++;
        if ({i8.busy, i8.done, i8.result, i8.result_hi, i8.c_out, i8.zero} !== {2'b00, 16'h0000, 2'b01}) begin
            fails++; $display("FAIL reset_state8 got busy=%b done=%b r=%h hi=%h c=%b z=%b want 0 0 00 00 0 1",
                              i8.busy, i8.done, i8.result, i8.result_hi, i8.c_out, i8.zero);
        end
        tests++;
        if ({i32.busy, i32.done, i32.result, i32.result_hi, i32.c_out, i32.zero} !== {2'b00, 64'd0, 2'b01}) begin
            fails++; $display("FAIL reset_state32 got busy=%b done=%b r=%h z=%b want 0 0 0 1",
                              i32.busy, i32.done, i32.result, i32.zero);
        end
        reset = 1'b0;
        tick();
        issue8(OP_ADD, 8'h03, 8'h04, lat, r, hi, c, z);
        tests++;
        if (r !== 8'h07 || lat !== 1) begin
            fails++; $display("FAIL pre_reset_add got r=%h lat=%0d want 07 1", r, lat);
        end
        i8.start = 1'b1; i8.ALUctl = OP_MUL; i8.a = 8'hFF; i8.b = 8'hFF;
        tick();
        i8.start = 1'b0;
        tick(); tick();
        tests++;
        if (i8.busy !== 1'b1) begin
            fails++; $display("FAIL mul_running got busy=%b want 1", i8.busy);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (i8.busy !== 1'b0) begin
            fails++; $display("FAIL reset_async got busy=%b want 0", i8.busy);
        end
        tick();
        tests++;
        if ({i8.busy, i8.done, i8.result, i8.result_hi, i8.c_out, i8.zero} !== {2'b00, 16'h0000, 2'b01}) begin
            fails++; $display("FAIL reset_mid_mul got busy=%b done=%b r=%h hi=%h c=%b z=%b want 0 0 00 00 0 1",
                              i8.busy, i8.done, i8.result, i8.result_hi, i8.c_out, i8.zero);
        end
        reset = 1'b0;
        tick(); tick();
        tests++;
        if (i8.done !== 1'b0 || i8.busy !== 1'b0) begin
            fails++; $display("FAIL reset_no_stale got done=%b busy=%b want 0 0", i8.done, i8.busy);
        end
        issue8(OP_ADD, 8'h10, 8'h20, lat, r, hi, c, z);
        tests++;
        if (r !== 8'h30 || hi !== 8'h00 || c !== 1'b0 || z !== 1'b0 || lat !== 1) begin
            fails++; $display("FAIL post_reset_add got r=%h hi=%h c=%b z=%b lat=%0d want 30 00 0 0 1", r, hi, c, z, lat);
        end
    endtask

    task automatic test_single_cycle();
        vec_t tbl [12];
        int lat;
        logic [7:0] r, hi;
        logic c, z;
        tbl = '{'{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1},
                '{OP_SUB, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0},
                '{OP_SLT, 8'h80, 8'h01, 8'h01, 1'b0, 1'b0},
                '{OP_SLT, 8'h7F, 8'h80, 8'h00, 1'b0, 1'b1},
                '{OP_SLT, 8'h80, 8'h7F, 8'h01, 1'b0, 1'b0},
                '{OP_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1},
                '{OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0},
                '{OP_OR,  8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0},
                '{OP_XOR, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1},
                '{OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0},
                '{4'b0011, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1},
                '{4'b1111, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1}};
        for (int i = 0; i < 12; i++) begin
            issue8(tbl[i].op, tbl[i].a, tbl[i].b, lat, r, hi, c, z);
            tests++;
            if (r !== tbl[i].r || hi !== 8'h00 || c !== tbl[i].c || z !== tbl[i].z || lat !== 1) begin
                fails++; $display("FAIL single_op%0d got r=%h hi=%h c=%b z=%b lat=%0d want %h 00 %b %b 1",
                                  i, r, hi, c, z, lat, tbl[i].r, tbl[i].c, tbl[i].z);
            end
        end
    endtask

    task automatic test_mul();
        int lat;
        logic [7:0] r, hi;
        logic c, z;
        logic hold_ok, quiet_ok;
        issue8(OP_MUL, 8'hFF, 8'hFF, lat, r, hi, c, z);
        tests++;
        if (r !== 8'h01 || hi !== 8'hFE || c !== 1'b0 || z !== 1'b0 || lat !== 9) begin
            fails++; $display("FAIL mul_ff_ff got r=%h hi=%h c=%b z=%b lat=%0d want 01 FE 0 0 9", r, hi, c, z, lat);
        end
        i8.start = 1'b1; i8.ALUctl = OP_MUL; i8.a = 8'h03; i8.b = 8'h05;
        tick();
        i8.start = 1'b0;
        hold_ok = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            if (i8.result !== 8'h01 || i8.done !== 1'b0 || i8.busy !== 1'b1) hold_ok = 1'b0;
            if (k == 2) begin i8.start = 1'b1; i8.ALUctl = OP_ADD; i8.a = 8'h01; i8.b = 8'h01; end
            if (k == 3) i8.start = 1'b0;
            tick();
        end
        tests++;
        if (!hold_ok) begin
            fails++; $display("FAIL mul_run_hold got hold_ok=0 want result 01 held, busy 1, done 0 during RUN");
        end
        tests++;
        if (i8.done !== 1'b1 || i8.busy !== 1'b0 || i8.result !== 8'h0F || i8.result_hi !== 8'h00) begin
            fails++; $display("FAIL mul_ignore_start got done=%b busy=%b r=%h hi=%h want 1 0 0F 00",
                              i8.done, i8.busy, i8.result, i8.result_hi);
        end
        quiet_ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (i8.done !== 1'b0 || i8.busy !== 1'b0 || i8.result !== 8'h0F) quiet_ok = 1'b0;
        end
        tests++;
        if (!quiet_ok) begin
            fails++; $display("FAIL mul_no_extra_done got extra activity after done want idle");
        end
    endtask

    task automatic test_back_to_back();
        i8.start = 1'b1; i8.ALUctl = OP_ADD; i8.a = 8'h11; i8.b = 8'h22;
        tick();
        tests++;
        if (i8.done !== 1'b1 || i8.result !== 8'h33) begin
            fails++; $display("FAIL b2b_first got done=%b r=%h want 1 33", i8.done, i8.result);
        end
        i8.ALUctl = OP_SUB; i8.a = 8'h50; i8.b = 8'h10;
        tick();
        tests++;
        if (i8.done !== 1'b0 || i8.result !== 8'h33) begin
            fails++; $display("FAIL b2b_start_in_done got done=%b r=%h want 0 33", i8.done, i8.result);
        end
        i8.ALUctl = OP_ADD; i8.a = 8'h01; i8.b = 8'h02;
        tick();
        i8.start = 1'b0;
        tests++;
        if (i8.done !== 1'b1 || i8.result !== 8'h03) begin
            fails++; $display("FAIL b2b_second got done=%b r=%h want 1 03", i8.done, i8.result);
        end
        tick();
    endtask

    task automatic test_divu();
        int lat;
        logic [7:0] r, hi;
        logic c, z;
`ifdef ALU_DIV_EN
        issue8(OP_DIVU, 8'h64, 8'h07, lat, r, hi, c, z);
        tests++;
        if (r !== 8'h0E || hi !== 8'h02 || c !== 1'b0 || z !== 1'b0 || lat !== 9) begin
            fails++; $display("FAIL divu_64_07 got r=%h hi=%h c=%b z=%b lat=%0d want 0E 02 0 0 9", r, hi, c, z, lat);
        end
        issue8(OP_DIVU, 8'h5A, 8'h00, lat, r, hi, c, z);
        tests++;
        if (r !== 8'hFF || hi !== 8'h5A || z !== 1'b0 || lat !== 9) begin
            fails++; $display("FAIL divu_by_zero got r=%h hi=%h z=%b lat=%0d want FF 5A 0 9", r, hi, z, lat);
        end
`else
        issue8(OP_DIVU, 8'h64, 8'h07, lat, r, hi, c, z);
        tests++;
        if (r !== 8'h00 || hi !== 8'h00 || c !== 1'b0 || z !== 1'b1 || lat !== 1) begin
            fails++; $display("FAIL divu_disabled got r=%h hi=%h c=%b z=%b lat=%0d want 00 00 0 1 1", r, hi, c, z, lat);
        end
`endif
    endtask

    task automatic test_random();
        logic [3:0] ops [8];
        logic [3:0] op;
        logic [31:0] x, y, er, ehi;
        logic ec, ez, overlap;
        int elat, lat, busy_n;
        ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_XOR, OP_MUL, OP_DIVU};
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 8) == 8) op = 4'($urandom);
            else op = ops[$urandom_range(0, 7)];
            x = pick32();
            y = pick32();
            model(op, x, y, er, ehi, ec, ez, elat);
            i32.start = 1'b1; i32.ALUctl = op; i32.a = x; i32.b = y;
            tick();
            i32.start = 1'b0; i32.a = $urandom; i32.b = $urandom;
            lat = 1;
            busy_n = 0;
            while (i32.done !== 1'b1 && lat < 100) begin
                if (i32.busy === 1'b1) busy_n++;
                tick();
                lat++;
            end
            overlap = (i32.busy !== 1'b0);
            tests++;
            if (i32.done !== 1'b1 || lat !== elat || i32.result !== er || i32.result_hi !== ehi ||
                i32.c_out !== ec || i32.zero !== ez) begin
                fails++; $display("FAIL rand%0d op=%b a=%h b=%h got r=%h hi=%h c=%b z=%b lat=%0d want %h %h %b %b %0d",
                                  n, op, x, y, i32.result, i32.result_hi, i32.c_out, i32.zero, lat, er, ehi, ec, ez, elat);
            end
            tick();
            tests++;
            if (overlap || busy_n !== elat - 1 || i32.done !== 1'b0) begin
                fails++; $display("FAIL rand_hs%0d got overlap=%b busy_cycles=%0d done_after=%b want 0 %0d 0",
                                  n, overlap, busy_n, i32.done, elat - 1);
            end
            repeat ($urandom_range(0, 1)) tick();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_cycle();
        test_mul();
        test_back_to_back();
        test_divu();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
